ob_cn_sched: RTL

- Controller for the N-entry conditional-order table.
- Owns the entry occupancy vector and performs lowest-index-free allocation of issued commands.
- Round-robin arbitrates matured entries onto a single registered maturity output with a valid/accept handshake.
- Issues per-entry allocate/deallocate strobes to the entries and supports a whole-table flush.

---
 rtl/ob_cn_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ob_cn_sched.sv
// Conditional-order table scheduler: lowest-free allocation, occupancy tracking
// and round-robin presentation of matured entries over a valid/accept handshake.
package ob_pkg;
  typedef logic [15:0] cmd_t;
endpackage

module ob_cn_sched #(
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld_r,
  input  ob_pkg::cmd_t         cmd_r,
  output logic                 cmd_rdy,
  input  logic                 flush,
  input  logic [N-1:0]         entry_mtr,
  input  ob_pkg::cmd_t [N-1:0] entry_cmd,
  output logic [N-1:0]         al_vld,
  output logic [N-1:0]         dl_vld,
  output logic [N-1:0]         occ_r,
  output logic [CNT_W-1:0]     count_r,
  output logic                 full_r,
  output logic                 ovf_r,
  input  logic                 mtr_accept,
  output logic                 mtr_vld_r,
  output ob_pkg::cmd_t         mtr_r
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           r_state;
  logic [N-1:0]     r_occ;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_ovf;
  ob_pkg::cmd_t     r_mtr;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_sel;

  logic [N-1:0]     w_sel_oh;
  logic [N-1:0]     w_al;
  logic [N-1:0]     w_dl;
  logic [N-1:0]     w_occ_nxt;
  logic [N-1:0]     w_cand;
  logic             w_accept;
  logic             w_al_found;
  logic             w_found;
  logic [PTR_W-1:0] w_start;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W:0]   w_sum;
  logic             w_unused;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == N-1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // The command payload is stored by the table entries, not here.
  assign w_unused  = ^cmd_r;

  assign w_sel_oh  = {{(N-1){1'b0}}, 1'b1} << r_sel;
  assign w_accept  = (r_state == PRESENT) & mtr_accept & ~flush;
  assign w_dl      = flush ? r_occ : (w_accept ? w_sel_oh : '0);
  assign w_occ_nxt = (r_occ | w_al) & ~w_dl;
  // The presented entry stays occupied until accepted, so exclude it explicitly.
  assign w_cand    = entry_mtr & r_occ & ~((r_state == PRESENT) ? w_sel_oh : '0);
  assign w_start   = w_accept ? inc_ptr(r_sel) : r_rr_ptr;

  always_comb begin
    w_al       = '0;
    w_al_found = 1'b0;
    if (cmd_vld_r & ~r_full & ~flush) begin
      for (int i = 0; i < N; i++) begin
        if (!w_al_found && !r_occ[i]) begin
          w_al[i]    = 1'b1;
          w_al_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, w_start} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N)) w_sum = w_sum - (PTR_W+1)'(N);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && w_cand[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_occ    <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mtr    <= '0;
      r_rr_ptr <= '0;
      r_sel    <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_count <= popcount(w_occ_nxt);
      r_full  <= &w_occ_nxt;
      r_ovf   <= cmd_vld_r & r_full & ~flush;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        if (w_accept) r_rr_ptr <= inc_ptr(r_sel);
        if (r_state == IDLE || w_accept) begin
          if (w_found) begin
            r_state <= PRESENT;
            r_sel   <= w_win;
            r_mtr   <= entry_cmd[w_win];
          end else begin
            r_state <= IDLE;
          end
        end
      end
    end
  end

  assign cmd_rdy   = ~r_full;
  assign al_vld    = w_al;
  assign dl_vld    = w_dl;
  assign occ_r     = r_occ;
  assign count_r   = r_count;
  assign full_r    = r_full;
  assign ovf_r     = r_ovf;
  assign mtr_vld_r = (r_state == PRESENT);
  assign mtr_r     = r_mtr;

endmodule
